// File: rtl/mar_pkg.sv
// Shared types and helpers for the burst-capable memory address register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mar_pkg;

    localparam int MAR_AW_DEF = 4;
    localparam int MAR_LW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAST = 2'd2
    } mar_state_t;

    // Callers truncate the result to their own address width.
    function automatic logic [31:0] mar_next_addr(input logic [31:0] addr, input logic dir);
        return dir ? (addr - 32'd1) : (addr + 32'd1);
    endfunction

endpackage

// File: rtl/mar_addr_cnt.sv
// AW-bit address register with load, single-step up/down and wrap detection.
// Latency: load/step visible one cycle after the edge; wrap_evt is combinational.
// Backpressure: none; the owner decides when to load or step.
module mar_addr_cnt
    import mar_pkg::*;
#(
    parameter int AW = MAR_AW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          step,
    input  logic          dir,
    output logic [AW-1:0] addr,
    output logic          wrap_evt
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_nxt;
    logic          at_edge;

    assign addr_nxt = AW'(mar_next_addr(32'(addr_q), dir));
    // The edge that wraps depends on direction: all-ones going up, zero going down.
    assign at_edge  = dir ? (addr_q == '0) : (addr_q == '1);
    assign wrap_evt = step & at_edge;
    assign addr     = addr_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= load_val;
        end else if (step) begin
            addr_q <= addr_nxt;
        end
    end

endmodule

// File: rtl/mar_burst.sv
// Memory address register with autonomous LEN-beat burst; MAR_DIR_EN adds a descending-burst dir input.
// Latency: burst of N beats with ack high spends N cycles in req plus one done cycle.
// Backpressure: address held while req=1 and ack=0; LM/start ignored while busy.
module mar_burst
    import mar_pkg::*;
#(
    parameter int AW = MAR_AW_DEF,
    parameter int LW = MAR_LW_DEF
) (
    input  logic          clk,
    input  logic          clr,
`ifdef MAR_DIR_EN
    input  logic          dir,
`endif
    input  logic          LM,
    input  logic [AW-1:0] MAR_in,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          ack,
    output logic [AW-1:0] MAR_out,
    output logic          req,
    output logic          busy,
    output logic          done,
    output logic          wrap
);

    mar_state_t    state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic          zdone_q, zdone_d;
    logic          ld, step, wrap_evt;
    logic          dir_q;
    logic          burst_go;

    assign burst_go = (state_q == IDLE) && start && (len != '0);

`ifdef MAR_DIR_EN
    // Direction is latched once per burst so a toggling dir mid-burst has no effect.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dir_q <= 1'b0;
        end else if (burst_go) begin
            dir_q <= dir;
        end
    end
`else
    assign dir_q = 1'b0;
`endif

    mar_addr_cnt #(.AW(AW)) u_addr (
        .clk      (clk),
        .clr      (clr),
        .load     (ld),
        .load_val (MAR_in),
        .step     (step),
        .dir      (dir_q),
        .addr     (MAR_out),
        .wrap_evt (wrap_evt)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            zdone_q <= zdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        zdone_d = 1'b0;
        ld      = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                ld = LM;
                if (start) begin
                    wrap_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = REQ;
                    end else begin
                        // Zero-length burst: report completion without touching the RAM.
                        zdone_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (ack) begin
                    if (cnt_q != LW'(1)) begin
                        step  = 1'b1;
                        cnt_d = cnt_q - LW'(1);
                        if (wrap_evt) begin
                            wrap_d = 1'b1;
                        end
                    end else begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req  = (state_q == REQ);
    assign busy = (state_q != IDLE);
    assign done = (state_q == LAST) || zdone_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_mar_burst.sv
// Self-checking bench for mar_burst: expected {wrap,addr} per accepted beat are queued at stimulus time.
module tb_mar_burst;

    localparam int AW = 4;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          LM;
    logic [AW-1:0] MAR_in;
    logic          start;
    logic [LW-1:0] len;
    logic          ack;
    logic [AW-1:0] MAR_out;
    logic          req, busy, done, wrap;
`ifdef MAR_DIR_EN
    logic          dir;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q[$];
    int req_cyc  = 0;
    int busy_cyc = 0;
    int done_cnt = 0;
    bit stall_prev = 1'b0;
    logic [AW-1:0] stall_addr = '0;

    always #5 clk = ~clk;

    mar_burst #(.AW(AW), .LW(LW)) dut (
        .clk     (clk),
        .clr     (clr),
`ifdef MAR_DIR_EN
        .dir     (dir),
`endif
        .LM      (LM),
        .MAR_in  (MAR_in),
        .start   (start),
        .len     (len),
        .ack     (ack),
        .MAR_out (MAR_out),
        .req     (req),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic w, input logic [AW-1:0] a);
        return 32'({w, a});
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a);
        LM     = 1'b1;
        MAR_in = a;
        cyc();
        LM     = 1'b0;
    endtask

    // Drives ack (low for 'stall' cycles per beat, then high) until done appears.
    task automatic wait_done(input int stall, input string tag);
        int k = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (req) begin
                if (k == stall) begin
                    ack = 1'b1;
                    k   = 0;
                end else begin
                    ack = 1'b0;
                    k++;
                end
            end
            cyc();
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // Monitor: beats are accepted on the edge following a negedge with req && ack.
    always @(negedge clk) begin
        if (!clr) begin
            if (busy) busy_cyc++;
            if (req)  req_cyc++;
            if (done) done_cnt++;
            if (stall_prev && req) chk("stall_hold", 32'(MAR_out), 32'(stall_addr));
            stall_prev = req && !ack;
            stall_addr = MAR_out;
            if (req && ack) begin
                if (q.size() == 0) begin
                    chk("beat_extra", ent(wrap, MAR_out), 32'hDEAD);
                end else begin
                    chk("beat", ent(wrap, MAR_out), q.pop_front());
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, d0, b0;
        bit hit;
        clr    = 1'b1;
        LM     = 1'b0;
        start  = 1'b0;
        ack    = 1'b0;
        MAR_in = '0;
        len    = '0;
`ifdef MAR_DIR_EN
        dir    = 1'b0;
`endif
        #12;
        chk("rst_addr", 32'(MAR_out), 32'd0);
        chk("rst_flags", 32'({req, busy, done, wrap}), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        cyc();

        // Load and hold
        load(4'd5);
        chk("load", 32'(MAR_out), 32'd5);
        MAR_in = 4'd15;
        cyc();
        cyc();
        chk("hold", 32'(MAR_out), 32'd5);

        // Four-beat burst, ack tied high
        load(4'd3);
        ack = 1'b1;
        r0 = req_cyc; d0 = done_cnt; b0 = busy_cyc;
        for (int a = 3; a <= 6; a++) q.push_back(ent(1'b0, 4'(a)));
        start = 1'b1; len = 4'd4;
        cyc();
        start = 1'b0;
        wait_done(0, "b4");
        chk("b4_req_cycles", 32'(req_cyc - r0), 32'd4);
        chk("b4_last_addr", 32'(MAR_out), 32'd6);
        chk("b4_wrap", 32'(wrap), 32'd0);
        cyc();
        chk("b4_busy_cycles", 32'(busy_cyc - b0), 32'd5);
        chk("b4_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("b4_idle", 32'({busy, req, done}), 32'd0);
        chk("b4_sb_empty", 32'(q.size()), 32'd0);

        // Wrap with two stall cycles per beat; LM/start held high while busy must be ignored
        load(4'd14);
        ack = 1'b0;
        q.push_back(ent(1'b0, 4'd14));
        q.push_back(ent(1'b0, 4'd15));
        q.push_back(ent(1'b1, 4'd0));
        start = 1'b1; len = 4'd3;
        cyc();
        LM = 1'b1; MAR_in = 4'd7; len = 4'd9;
        wait_done(2, "wrap");
        LM = 1'b0; start = 1'b0;
        chk("wrap_set", 32'(wrap), 32'd1);
        chk("wrap_last_addr", 32'(MAR_out), 32'd0);
        chk("wrap_sb_empty", 32'(q.size()), 32'd0);
        cyc();
        cyc();
        chk("wrap_sticky", 32'(wrap), 32'd1);
        chk("wrap_idle_addr", 32'(MAR_out), 32'd0);

        // Zero-length burst
        r0 = req_cyc; d0 = done_cnt;
        start = 1'b1; len = 4'd0;
        cyc();
        start = 1'b0;
        wait_done(0, "len0");
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_wrap_cleared", 32'(wrap), 32'd0);
        chk("len0_addr", 32'(MAR_out), 32'd0);
        cyc();
        chk("len0_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("len0_req_cycles", 32'(req_cyc - r0), 32'd0);

        // Load and start in the same cycle
        ack = 1'b1;
        q.push_back(ent(1'b0, 4'd9));
        q.push_back(ent(1'b0, 4'd10));
        LM = 1'b1; MAR_in = 4'd9; start = 1'b1; len = 4'd2;
        cyc();
        LM = 1'b0; start = 1'b0;
        wait_done(0, "ldst");
        chk("ldst_last_addr", 32'(MAR_out), 32'd10);
        chk("ldst_sb_empty", 32'(q.size()), 32'd0);
        cyc();

        // Asynchronous reset in the middle of a burst
        load(4'd5);
        ack = 1'b1;
        q.push_back(ent(1'b0, 4'd5));
        q.push_back(ent(1'b0, 4'd6));
        d0 = done_cnt;
        start = 1'b1; len = 4'd6;
        cyc();
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req && MAR_out == 4'd7) begin
                hit = 1'b1;
                break;
            end
            cyc();
        end
        chk("rst_reach7", 32'(hit), 32'd1);
        #2;
        clr = 1'b1;
        #1;
        chk("rst_mid_addr", 32'(MAR_out), 32'd0);
        chk("rst_mid_flags", 32'({req, busy, done}), 32'd0);
        chk("rst_mid_sb", 32'(q.size()), 32'd0);
        q.delete();
        cyc();
        cyc();
        chk("rst_no_done_out", 32'(done), 32'd0);
        clr = 1'b0;
        cyc();
        chk("rst_no_done_cnt", 32'(done_cnt - d0), 32'd0);
        q.push_back(ent(1'b0, 4'd0));
        q.push_back(ent(1'b0, 4'd1));
        start = 1'b1; len = 4'd2;
        cyc();
        start = 1'b0;
        wait_done(0, "post_rst");
        chk("post_rst_addr", 32'(MAR_out), 32'd1);
        chk("post_rst_sb_empty", 32'(q.size()), 32'd0);
        cyc();

`ifdef MAR_DIR_EN
        // Descending burst across zero
        load(4'd1);
        ack = 1'b1;
        q.push_back(ent(1'b0, 4'd1));
        q.push_back(ent(1'b0, 4'd0));
        q.push_back(ent(1'b1, 4'd15));
        dir = 1'b1; start = 1'b1; len = 4'd3;
        cyc();
        start = 1'b0; dir = 1'b0;
        wait_done(0, "desc");
        chk("desc_wrap", 32'(wrap), 32'd1);
        chk("desc_last_addr", 32'(MAR_out), 32'd15);
        chk("desc_sb_empty", 32'(q.size()), 32'd0);
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
